// File: rtl/transaction_sequencer_if.sv
// Request/status bundle between the game request logic and the transaction sequencer.
interface transaction_sequencer_if #(parameter int WIDTH = 8);
    logic             req_valid;
    logic             req_person;
    logic [WIDTH-1:0] req_amount;
    logic             req_ready;
    logic             busy;
    logic             done;
    logic             rejected;
    logic [WIDTH-1:0] p1_balance;
    logic [WIDTH-1:0] p2_balance;
    logic [7:0]       txn_count;

    modport master (
        output req_valid, req_person, req_amount,
        input  req_ready, busy, done, rejected, p1_balance, p2_balance, txn_count
    );
    modport slave (
        input  req_valid, req_person, req_amount,
        output req_ready, busy, done, rejected, p1_balance, p2_balance, txn_count
    );
endinterface

// File: rtl/transaction_sequencer.sv
// Two-player coin-transfer sequencer: accept, check, atomically apply, report.
// Optional payee-overflow rejection is enabled by defining OVERFLOW_CHECK_EN.
module transaction_sequencer #(
    parameter int WIDTH        = 8,
    parameter int INIT_BALANCE = 100
) (
    input logic                    clock,
    input logic                    reset,
    transaction_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, APPLY, DONE, REJECT} state_t;

    localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_BALANCE);

    state_t           state, state_nxt;
    logic             person_q;
    logic [WIDTH-1:0] amount_q;
    logic [WIDTH-1:0] p1, p2;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] payer, payee;
    logic             refuse;

    assign payer = person_q ? p2 : p1;
    assign payee = person_q ? p1 : p2;

`ifdef OVERFLOW_CHECK_EN
    logic [WIDTH:0] payee_sum;
    assign payee_sum = {1'b0, payee} + {1'b0, amount_q};
    assign refuse    = (amount_q == '0) || (amount_q > payer) || payee_sum[WIDTH];
`else
    assign refuse    = (amount_q == '0) || (amount_q > payer);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = CHECK;
            CHECK:   state_nxt = refuse ? REJECT : APPLY;
            APPLY:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            REJECT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and balances; both balances move on the APPLY exit edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            person_q <= 1'b0;
            amount_q <= '0;
            p1       <= INIT;
            p2       <= INIT;
            cnt      <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                person_q <= bus.req_person;
                amount_q <= bus.req_amount;
            end
            if (state == APPLY) begin
                if (person_q) begin
                    p2 <= p2 - amount_q;
                    p1 <= p1 + amount_q;
                end else begin
                    p1 <= p1 - amount_q;
                    p2 <= p2 + amount_q;
                end
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.rejected  = (state == REJECT);
    end

    assign bus.p1_balance = p1;
    assign bus.p2_balance = p2;
    assign bus.txn_count  = cnt;
endmodule

// File: tb/tb_transaction_sequencer.sv
// Randomized self-checking bench for transaction_sequencer with a balance-level model.
module tb_transaction_sequencer;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    transaction_sequencer_if #(.WIDTH(W)) bus();
    transaction_sequencer_if #(.WIDTH(W)) bus_hi();

    transaction_sequencer #(.WIDTH(W), .INIT_BALANCE(100)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave));
    // Second instance starts at 200/200 so payee overflow is reachable.
    transaction_sequencer #(.WIDTH(W), .INIT_BALANCE(200)) dut_hi (
        .clock(clock), .reset(reset), .bus(bus_hi.slave));

    int errors = 0;
    int checks = 0;
    logic [W-1:0] m_bal [2];
    logic [7:0]   m_cnt;

`ifdef OVERFLOW_CHECK_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus_hi.req_valid = 1'b0;
        m_bal[0] = 8'd100;
        m_bal[1] = 8'd100;
        m_cnt = 8'd0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Runs one transfer starting at a negedge with the DUT idle; returns at the
    // negedge where req_ready is back high, so calls chain back to back.
    task automatic run_txn(input logic person, input logic [W-1:0] amount, input bit hold);
        logic         exp_rej;
        logic [W:0]   psum;
        logic [W-1:0] np1, np2;
        psum    = {1'b0, m_bal[!person]} + {1'b0, amount};
        exp_rej = (amount == 0) || (amount > m_bal[person]) || (OVF && psum > 9'd255);
        np1 = person ? m_bal[0] + amount : m_bal[0] - amount;
        np2 = person ? m_bal[1] - amount : m_bal[1] + amount;

        bus.req_valid = 1'b1; bus.req_person = person; bus.req_amount = amount;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready: got %b want 1", bus.req_ready);
        end
        @(negedge clock);
        bus.req_valid = hold; bus.req_person = 1'($urandom); bus.req_amount = W'($urandom);
        checks++;
        if ({bus.req_ready, bus.busy, bus.done, bus.rejected} !== 4'b0100) begin
            errors++; $display("FAIL check_flags: got %b want 0100",
                {bus.req_ready, bus.busy, bus.done, bus.rejected});
        end
        @(negedge clock);
        checks++;
        if ({bus.req_ready, bus.busy, bus.done, bus.rejected} !== (exp_rej ? 4'b0101 : 4'b0100) ||
            bus.p1_balance !== m_bal[0] || bus.p2_balance !== m_bal[1]) begin
            errors++; $display("FAIL cycle2: flags %b bal %0d/%0d want flags %b bal %0d/%0d",
                {bus.req_ready, bus.busy, bus.done, bus.rejected}, bus.p1_balance, bus.p2_balance,
                exp_rej ? 4'b0101 : 4'b0100, m_bal[0], m_bal[1]);
        end
        if (!exp_rej) begin
            @(negedge clock);
            m_bal[0] = np1; m_bal[1] = np2; m_cnt = m_cnt + 8'd1;
            checks++;
            if ({bus.req_ready, bus.busy, bus.done, bus.rejected} !== 4'b0110 ||
                bus.p1_balance !== m_bal[0] || bus.p2_balance !== m_bal[1] || bus.txn_count !== m_cnt) begin
                errors++; $display("FAIL done_cycle: flags %b bal %0d/%0d cnt %0d want 0110 %0d/%0d cnt %0d",
                    {bus.req_ready, bus.busy, bus.done, bus.rejected}, bus.p1_balance, bus.p2_balance,
                    bus.txn_count, m_bal[0], m_bal[1], m_cnt);
            end
        end
        @(negedge clock);
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.req_ready, bus.busy, bus.done, bus.rejected} !== 4'b1000 ||
            bus.p1_balance !== m_bal[0] || bus.p2_balance !== m_bal[1] || bus.txn_count !== m_cnt) begin
            errors++; $display("FAIL back_idle: flags %b bal %0d/%0d cnt %0d want 1000 %0d/%0d cnt %0d",
                {bus.req_ready, bus.busy, bus.done, bus.rejected}, bus.p1_balance, bus.p2_balance,
                bus.txn_count, m_bal[0], m_bal[1], m_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_person = 1'b0; bus.req_amount = '0;
        bus_hi.req_valid = 1'b0; bus_hi.req_person = 1'b0; bus_hi.req_amount = '0;
        #12;
        checks++;
        if ({bus.req_ready, bus.busy, bus.done, bus.rejected} !== 4'b1000 ||
            bus.p1_balance !== 8'd100 || bus.p2_balance !== 8'd100 || bus.txn_count !== 8'd0) begin
            errors++; $display("FAIL reset_state: flags %b bal %0d/%0d cnt %0d want 1000 100/100 cnt 0",
                {bus.req_ready, bus.busy, bus.done, bus.rejected}, bus.p1_balance, bus.p2_balance, bus.txn_count);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        run_txn(1'b0, 8'd30, 1'b0);
        checks++;
        if (m_bal[0] !== 8'd70 || m_bal[1] !== 8'd130) begin
            errors++; $display("FAIL model_basic: got %0d/%0d want 70/130", m_bal[0], m_bal[1]);
        end
        apply_reset();
        run_txn(1'b1, 8'd100, 1'b0);
        run_txn(1'b0, 8'd0, 1'b0);
        checks++;
        if (bus.p1_balance !== 8'd200 || bus.p2_balance !== 8'd0 || bus.txn_count !== 8'd1) begin
            errors++; $display("FAIL drain_p2: got %0d/%0d cnt %0d want 200/0 cnt 1",
                bus.p1_balance, bus.p2_balance, bus.txn_count);
        end
    endtask

    task automatic test_held_valid();
        apply_reset();
        run_txn(1'b0, 8'd101, 1'b1);
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.p1_balance !== 8'd100 || bus.txn_count !== 8'd0) begin
            errors++; $display("FAIL held_valid: busy %b p1 %0d cnt %0d want 0 100 0",
                bus.busy, bus.p1_balance, bus.txn_count);
        end
    endtask

    task automatic test_back_to_back_random();
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            logic p;
            logic [W-1:0] a;
            p = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       a = '0;
                1:       a = m_bal[p];
                2:       a = m_bal[p] + 8'd1;
                default: a = W'($urandom_range(1, 120));
            endcase
            run_txn(p, a, 1'($urandom_range(0, 1)));
        end
        checks++;
        if ({1'b0, bus.p1_balance} + {1'b0, bus.p2_balance} !== 9'd200) begin
            errors++; $display("FAIL sum_invariant: got %0d want 200",
                {1'b0, bus.p1_balance} + {1'b0, bus.p2_balance});
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.req_valid = 1'b1; bus.req_person = 1'b0; bus.req_amount = 8'd10;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, bus.busy, bus.done, bus.rejected} !== 4'b1000 ||
            bus.p1_balance !== 8'd100 || bus.p2_balance !== 8'd100 || bus.txn_count !== 8'd0) begin
            errors++; $display("FAIL reset_mid: flags %b bal %0d/%0d cnt %0d want 1000 100/100 cnt 0",
                {bus.req_ready, bus.busy, bus.done, bus.rejected}, bus.p1_balance, bus.p2_balance, bus.txn_count);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({bus.req_ready, bus.busy, bus.done, bus.rejected} !== 4'b1000 || bus.p1_balance !== 8'd100) begin
                errors++; $display("FAIL reset_mid_after: flags %b p1 %0d want 1000 100",
                    {bus.req_ready, bus.busy, bus.done, bus.rejected}, bus.p1_balance);
            end
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] e1, e2;
        logic [1:0]   ef;
        apply_reset();
        e1 = OVF ? 8'd200 : 8'd140;
        e2 = OVF ? 8'd200 : 8'd4;
        ef = OVF ? 2'b01 : 2'b10;
        bus_hi.req_valid = 1'b1; bus_hi.req_person = 1'b0; bus_hi.req_amount = 8'd60;
        @(negedge clock);
        bus_hi.req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (bus_hi.rejected !== ef[0] || bus_hi.done !== 1'b0) begin
            errors++; $display("FAIL ovf_cycle2: rej %b done %b want %b 0", bus_hi.rejected, bus_hi.done, ef[0]);
        end
        if (!OVF) @(negedge clock);
        checks++;
        if (bus_hi.done !== ef[1] || bus_hi.p1_balance !== e1 || bus_hi.p2_balance !== e2) begin
            errors++; $display("FAIL ovf_result: done %b bal %0d/%0d want %b %0d/%0d",
                bus_hi.done, bus_hi.p1_balance, bus_hi.p2_balance, ef[1], e1, e2);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_valid();
        test_back_to_back_random();
        test_reset_mid();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
